// File: rtl/hosted_axi_rd_arbiter.sv
// Round-robin arbiter sharing one hosted AXI read path between NREQ masters.
// One burst in flight at a time; R beats are steered back to the granted master.
module hosted_axi_rd_arbiter #(
   parameter int NREQ = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   m_arvalid,
   output logic [NREQ-1:0]   m_arready,
   input  logic [NREQ*32-1:0] m_araddr,
   input  logic [NREQ*8-1:0] m_arlen,
   input  logic [NREQ*3-1:0] m_arsize,
   input  logic [NREQ*2-1:0] m_arburst,
   output logic [NREQ-1:0]   m_rvalid,
   input  logic [NREQ-1:0]   m_rready,
   output logic [31:0]       m_rdata,
   output logic [1:0]        m_rresp,
   output logic              m_rlast,
   output logic              sys_arvalid,
   input  logic              sys_arready,
   output logic [7:0]        sys_arid,
   output logic [31:0]       sys_araddr,
   output logic [7:0]        sys_arlen,
   output logic [2:0]        sys_arsize,
   output logic [1:0]        sys_arburst,
   input  logic              sys_rvalid,
   output logic              sys_rready,
   input  logic [31:0]       sys_rdata,
   input  logic [1:0]        sys_rresp,
   input  logic              sys_rlast
);

   localparam int GW = $clog2(NREQ);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0]    state;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] grant;
   logic [GW-1:0] pick;
   logic [GW-1:0] idx;
   logic          found;

   // first valid requester at or after rr_ptr, wrapping
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = GW'((int'(rr_ptr) + i) % NREQ);
         if (!found && m_arvalid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      m_arready = '0;
      if (state == IDLE && found)
         m_arready[pick] = 1'b1;
   end

   always_comb begin
      m_rvalid   = '0;
      sys_rready = 1'b0;
      if (state == DATA) begin
         m_rvalid[grant] = sys_rvalid;
         sys_rready      = m_rready[grant];
      end
   end

   assign m_rdata  = sys_rdata;
   assign m_rresp  = sys_rresp;
   assign m_rlast  = sys_rlast;
   assign sys_arid = 8'(grant);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant       <= '0;
         sys_arvalid <= 1'b0;
         sys_araddr  <= '0;
         sys_arlen   <= '0;
         sys_arsize  <= '0;
         sys_arburst <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant       <= pick;
                  rr_ptr      <= (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
                  sys_araddr  <= m_araddr[int'(pick)*32 +: 32];
                  sys_arlen   <= m_arlen[int'(pick)*8 +: 8];
                  sys_arsize  <= m_arsize[int'(pick)*3 +: 3];
                  sys_arburst <= m_arburst[int'(pick)*2 +: 2];
                  sys_arvalid <= 1'b1;
                  state       <= ADDR;
               end
            end
            ADDR: begin
               if (sys_arready) begin
                  sys_arvalid <= 1'b0;
                  state       <= DATA;
               end
            end
            DATA: begin
               if (sys_rvalid && sys_rready && sys_rlast)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
